seq_dete_param: RTL

- Parametrised serial pattern detector for a valid-qualified bit stream.
- Supports a runtime-programmable pattern of PAT_W bits with a per-bit don't-care mask.
- Overlap or non-overlap matching is selectable at runtime.
- Provides a registered one-cycle match pulse and a saturating match counter.
- Sits on a serial ingress path as a framing / sync-word detector, configured by a local control block.

---
 rtl/seq_dete_param.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_dete_param.sv
// -----------------------------------------------------------------------------
// seq_dete_param
//
// Serial pattern detector for a valid-qualified bit stream. A PAT_W-bit
// pattern (MSB = oldest bit) and a per-bit compare mask are programmable at
// run time. Overlap or non-overlap matching can also be selected at run time.
// A registered one-cycle match pulse and a saturating match counter are
// produced.
//
// Ports:
//   clk          rising-edge clock
//   res_n        synchronous active-low reset
//   d_in         serial data bit, sampled only when valid=1
//   valid        qualifies d_in
//   cfg_load     one-cycle strobe: loads cfg_pat/cfg_mask/cfg_mode, restarts detection
//   cfg_pat      new pattern (MSB oldest)
//   cfg_mask     1 = bit compared, 0 = don't care
//   cfg_mode     1 = overlap, 0 = non-overlap
//   cnt_clr      synchronous clear of match_cnt (wins over a simultaneous hit)
//   pattern_dete registered match pulse
//   match_cnt    saturating number of matches
//   fill         valid bits accumulated toward the current window (0..PAT_W)
// -----------------------------------------------------------------------------
module seq_dete_param #(
    parameter int unsigned       PAT_W    = 4,
    parameter logic [PAT_W-1:0]  PAT_DEF  = 4'b1101,
    parameter logic              MODE_DEF = 1'b1,
    parameter int unsigned       CNT_W    = 8,
    localparam int unsigned      FILL_W   = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              d_in,
    input  logic              valid,
    input  logic              cfg_load,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic [PAT_W-1:0]  cfg_mask,
    input  logic              cfg_mode,
    input  logic              cnt_clr,
    output logic              pattern_dete,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-1:0]  pat_q,  pat_d;
    logic [PAT_W-1:0]  mask_q, mask_d;
    logic              mode_q, mode_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              dete_q, dete_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    logic [PAT_W-1:0]  new_hist;
    logic [FILL_W-1:0] fill_inc;
    logic              hit;

    // Window candidate if d_in is taken this cycle; fill saturates at PAT_W.
    assign new_hist = {hist_q[PAT_W-2:0], d_in};
    assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    assign hit      = (fill_inc == FILL_FULL) &&
                      (((new_hist ^ pat_q) & mask_q) == '0);

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path
        // through the branches leaves it unassigned (which would infer a latch).
        pat_d  = pat_q;
        mask_d = mask_q;
        mode_d = mode_q;
        hist_d = hist_q;
        fill_d = fill_q;
        dete_d = 1'b0;
        cnt_d  = cnt_q;

        if (cfg_load) begin
            // New configuration restarts detection; a same-cycle sample is dropped.
            pat_d  = cfg_pat;
            mask_d = cfg_mask;
            mode_d = cfg_mode;
            hist_d = '0;
            fill_d = '0;
        end else if (valid) begin
            hist_d = new_hist;
            dete_d = hit;
            // Non-overlap: the next window must be built from fresh samples.
            fill_d = (hit && !mode_q) ? '0 : fill_inc;
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (dete_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!res_n) begin
            pat_q  <= PAT_DEF;
            mask_q <= '1;
            mode_q <= MODE_DEF;
            hist_q <= '0;
            fill_q <= '0;
            dete_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            dete_q <= dete_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pattern_dete = dete_q;
    assign match_cnt    = cnt_q;
    assign fill         = fill_q;

endmodule
